pipe_ctrl: RTL and testbench

Parametrised pipeline control chain for the Riscv151 core family. It tracks one control word per stage and manages:
- the global stall (memory stall plus a multi-cycle load pause);
- redirect squash with a configurable post-jump fetch penalty;
- load-use interlock bubbles.

It replaces the hand-wired flag buffers, the branch_delay flop and the pause logic. The datapath registers use its stage_en outputs as clock enables.

---
 rtl/pipe_ctrl_pkg.sv | 32 +++
 rtl/pipe_stage_reg.sv | 34 +++
 rtl/pipe_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control chain: FSM states, control-word
// field positions and counter sizing.
package pipe_ctrl_pkg;

    typedef enum logic {
        SQ_RUN    = 1'b0,
        SQ_SQUASH = 1'b1
    } sq_state_t;

    typedef enum logic {
        LP_IDLE  = 1'b0,
        LP_PAUSE = 1'b1
    } lp_state_t;

    // Bit positions inside the 8-bit control word carried down the pipe.
    localparam int CTRL_REG_WE      = 0;
    localparam int CTRL_CSR_W       = 1;
    localparam int CTRL_MEM_WE      = 2;
    localparam int CTRL_MEM_RR      = 3;
    localparam int CTRL_JUMP        = 4;
    localparam int CTRL_FUNCT3_LSB  = 5;
    localparam int CTRL_W_DEFAULT   = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int cnt_w(input int kill_cycles, input int load_lat);
        return $clog2(max2(kill_cycles, load_lat) + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: valid bit plus control word. Kill and bubble both load
// an empty slot; an invalid slot always carries a zero control word.
module pipe_stage_reg
    import pipe_ctrl_pkg::*;
#(
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              kill,
    input  logic              bubble,
    input  logic              src_valid,
    input  logic [CTRL_W-1:0] src_ctrl,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (en) begin
            if (kill || bubble || !src_valid) begin
                valid <= 1'b0;
                ctrl  <= '0;
            end else begin
                valid <= 1'b1;
                ctrl  <= src_ctrl;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control chain: per-stage valid/ctrl, global stall with load pause,
// redirect squash window and load-use interlock bubbles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES         = 3,
    parameter int CTRL_W         = CTRL_W_DEFAULT,
    parameter int REDIRECT_STAGE = 1,
    parameter int KILL_CYCLES    = 1,
    parameter int LOAD_LAT       = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic                     ext_stall,
    input  logic                     redirect,
    input  logic                     interlock,
    input  logic                     wb_load,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES*CTRL_W-1:0] stage_ctrl,
    output logic [STAGES-1:0]        stage_en,
    output logic                     fetch_en,
    output logic                     internal_stall,
    output logic                     squashing
);

    localparam int CW = cnt_w(KILL_CYCLES, LOAD_LAT);
    // The trigger cycle already stalls, so the registered count starts one lower.
    localparam int LP_FIRST = (LOAD_LAT > 0) ? LOAD_LAT - 1 : 0;

    sq_state_t         sq_state, sq_next;
    lp_state_t         lp_state, lp_next;
    logic [CW-1:0]     sq_cnt, sq_cnt_next;
    logic [CW-1:0]     lp_cnt, lp_cnt_next;
    logic              done, done_next;
    logic              lp_trig, redir_acc, il_eff;

    logic [STAGES-1:0]             vld;
    logic [STAGES-1:0][CTRL_W-1:0] ctl;

    assign stage_valid = vld;
    assign stage_ctrl  = ctl;

    assign lp_trig   = (LOAD_LAT > 0) && (lp_state == LP_IDLE) && wb_load
                       && vld[STAGES-1] && !done;
    assign redir_acc = redirect && !internal_stall && vld[REDIRECT_STAGE]
                       && (sq_state == SQ_RUN);
    assign il_eff    = interlock && !internal_stall && !redir_acc;

    // Reset lands in the squash window so the first fetch after release is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            sq_state <= SQ_SQUASH;
            sq_cnt   <= CW'(KILL_CYCLES);
            lp_state <= LP_IDLE;
            lp_cnt   <= '0;
            done     <= 1'b0;
        end else begin
            sq_state <= sq_next;
            sq_cnt   <= sq_cnt_next;
            lp_state <= lp_next;
            lp_cnt   <= lp_cnt_next;
            done     <= done_next;
        end
    end

    always_comb begin
        sq_next     = sq_state;
        sq_cnt_next = sq_cnt;
        lp_next     = lp_state;
        lp_cnt_next = lp_cnt;
        done_next   = internal_stall ? done : 1'b0;

        case (sq_state)
            SQ_RUN: begin
                if (redir_acc) begin
                    sq_next     = SQ_SQUASH;
                    sq_cnt_next = CW'(KILL_CYCLES);
                end
            end
            SQ_SQUASH: begin
                if (!internal_stall) begin
                    if (sq_cnt <= CW'(1)) begin
                        sq_next     = SQ_RUN;
                        sq_cnt_next = '0;
                    end else begin
                        sq_cnt_next = sq_cnt - CW'(1);
                    end
                end
            end
            default: sq_next = SQ_RUN;
        endcase

        // Pause counts every cycle; an external stall only stretches the freeze.
        case (lp_state)
            LP_IDLE: begin
                if (lp_trig) begin
                    if (LP_FIRST == 0) begin
                        lp_cnt_next = '0;
                        done_next   = 1'b1;
                    end else begin
                        lp_next     = LP_PAUSE;
                        lp_cnt_next = CW'(LP_FIRST);
                    end
                end
            end
            LP_PAUSE: begin
                if (lp_cnt <= CW'(1)) begin
                    lp_next     = LP_IDLE;
                    lp_cnt_next = '0;
                    done_next   = 1'b1;
                end else begin
                    lp_cnt_next = lp_cnt - CW'(1);
                end
            end
            default: lp_next = LP_IDLE;
        endcase
    end

    always_comb begin
        squashing      = (sq_state == SQ_SQUASH);
        internal_stall = ext_stall || (lp_state == LP_PAUSE) || lp_trig;
        stage_en       = {STAGES{!internal_stall}};
        stage_en[0]    = !internal_stall && !il_eff;
        fetch_en       = !internal_stall && !il_eff;
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic              src_valid;
        logic [CTRL_W-1:0] src_ctrl;
        logic              kill;
        logic              bubble;

        if (i == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_ctrl  = in_ctrl;
            assign kill      = redir_acc || squashing;
            assign bubble    = 1'b0;
        end else begin : g_body
            assign src_valid = vld[i-1];
            assign src_ctrl  = ctl[i-1];
            // Stages receiving instructions younger than the jump are emptied.
            assign kill      = redir_acc && (i <= REDIRECT_STAGE);
            assign bubble    = (i == 1) && il_eff;
        end

        pipe_stage_reg #(.CTRL_W(CTRL_W)) u_reg (
            .clk       (clk),
            .reset     (reset),
            .en        (stage_en[i]),
            .kill      (kill),
            .bubble    (bubble),
            .src_valid (src_valid),
            .src_ctrl  (src_ctrl),
            .valid     (vld[i]),
            .ctrl      (ctl[i])
        );
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one DUT with default kill/load timing and one
// with KILL_CYCLES=2, LOAD_LAT=2, both fed the same stimulus.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset, in_valid, ext_stall, redirect, interlock, wb_load;
    logic [7:0]  in_ctrl;

    logic [2:0]  a_valid, a_en;
    logic [23:0] a_ctrl;
    logic        a_fetch, a_stall, a_squash;

    logic [2:0]  valid, en;
    logic [23:0] ctrl;
    logic        fetch, stall, squash;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.STAGES(3), .CTRL_W(8), .REDIRECT_STAGE(1), .KILL_CYCLES(1), .LOAD_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .ext_stall(ext_stall), .redirect(redirect), .interlock(interlock), .wb_load(wb_load),
        .stage_valid(a_valid), .stage_ctrl(a_ctrl), .stage_en(a_en), .fetch_en(a_fetch),
        .internal_stall(a_stall), .squashing(a_squash)
    );

    pipe_ctrl #(.STAGES(3), .CTRL_W(8), .REDIRECT_STAGE(1), .KILL_CYCLES(2), .LOAD_LAT(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .ext_stall(ext_stall), .redirect(redirect), .interlock(interlock), .wb_load(wb_load),
        .stage_valid(valid), .stage_ctrl(ctrl), .stage_en(en), .fetch_en(fetch),
        .internal_stall(stall), .squashing(squash)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_ctrl = 8'h00;
        ext_stall = 1'b0; redirect = 1'b0; interlock = 1'b0; wb_load = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic feed(input logic [7:0] c);
        in_valid = 1'b1; in_ctrl = c;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_ctrl = 8'h00;
        ext_stall = 1'b0; redirect = 1'b0; interlock = 1'b0; wb_load = 1'b0;
        tick(); tick();
        n_checks++; if (valid !== 3'b000) begin n_fail++; $display("FAIL reset_valid: got %b expected 000", valid); end
        n_checks++; if (ctrl !== 24'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 000000", ctrl); end
        n_checks++; if (squash !== 1'b1) begin n_fail++; $display("FAIL reset_squash: got %b expected 1", squash); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    endtask

    task automatic test_fill();
        // Still in reset from test_reset; release with a word waiting.
        in_valid = 1'b1; in_ctrl = 8'hA5; reset = 1'b0;
        tick();
        n_checks++; if (a_valid[0] !== 1'b0) begin n_fail++; $display("FAIL fill_first_blocked: got %b expected 0", a_valid[0]); end
        n_checks++; if (a_squash !== 1'b0) begin n_fail++; $display("FAIL fill_squash_end: got %b expected 0", a_squash); end
        tick();
        n_checks++; if (a_valid !== 3'b001 || a_ctrl[7:0] !== 8'hA5) begin n_fail++; $display("FAIL fill_capture: got %b/%h expected 001/a5", a_valid, a_ctrl[7:0]); end
        tick();
        n_checks++; if (a_valid[2] !== 1'b0) begin n_fail++; $display("FAIL fill_not_yet: got %b expected 0", a_valid[2]); end
        tick();
        n_checks++; if (a_valid !== 3'b111 || a_ctrl[23:16] !== 8'hA5) begin n_fail++; $display("FAIL fill_stage2: got %b/%h expected 111/a5", a_valid, a_ctrl[23:16]); end
    endtask

    task automatic test_redirect();
        do_reset();
        feed(8'h11); feed(8'h22);
        redirect = 1'b1; in_ctrl = 8'h33;
        tick();
        redirect = 1'b0; in_ctrl = 8'h44;
        n_checks++; if (valid !== 3'b100 || ctrl !== 24'h110000) begin n_fail++; $display("FAIL redir_edge: got %b/%h expected 100/110000", valid, ctrl); end
        n_checks++; if (squash !== 1'b1) begin n_fail++; $display("FAIL redir_squash1: got %b expected 1", squash); end
        tick();
        n_checks++; if (valid !== 3'b000 || squash !== 1'b1) begin n_fail++; $display("FAIL redir_window: got %b/%b expected 000/1", valid, squash); end
        tick();
        n_checks++; if (valid[0] !== 1'b0 || squash !== 1'b0) begin n_fail++; $display("FAIL redir_end: got %b/%b expected 0/0", valid[0], squash); end
        tick();
        n_checks++; if (valid !== 3'b001 || ctrl[7:0] !== 8'h44) begin n_fail++; $display("FAIL redir_resume: got %b/%h expected 001/44", valid, ctrl[7:0]); end
    endtask

    task automatic test_load_pause();
        do_reset();
        feed(8'h61); feed(8'h62); feed(8'h63);
        wb_load = 1'b1; in_ctrl = 8'h64;
        #1;
        n_checks++; if (stall !== 1'b1 || fetch !== 1'b0) begin n_fail++; $display("FAIL pause_trigger: got %b/%b expected 1/0", stall, fetch); end
        tick();
        n_checks++; if (valid !== 3'b111 || ctrl !== 24'h616263 || stall !== 1'b1) begin n_fail++; $display("FAIL pause_hold1: got %b/%h/%b expected 111/616263/1", valid, ctrl, stall); end
        tick();
        n_checks++; if (ctrl !== 24'h616263 || stall !== 1'b0) begin n_fail++; $display("FAIL pause_hold2: got %h/%b expected 616263/0", ctrl, stall); end
        tick();
        n_checks++; if (ctrl !== 24'h626364) begin n_fail++; $display("FAIL pause_advance: got %h expected 626364", ctrl); end
        wb_load = 1'b0;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL pause_clear: got %b expected 0", stall); end
    endtask

    task automatic test_ext_stall();
        do_reset();
        feed(8'h71); feed(8'h72); feed(8'h73);
        ext_stall = 1'b1; in_ctrl = 8'h74;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (valid !== 3'b111 || ctrl !== 24'h717273 || fetch !== 1'b0) begin n_fail++; $display("FAIL ext_hold[%0d]: got %b/%h/%b expected 111/717273/0", k, valid, ctrl, fetch); end
        end
        ext_stall = 1'b0;
        tick();
        n_checks++; if (ctrl !== 24'h727374) begin n_fail++; $display("FAIL ext_resume1: got %h expected 727374", ctrl); end
        feed(8'h75);
        n_checks++; if (ctrl !== 24'h737475) begin n_fail++; $display("FAIL ext_resume2: got %h expected 737475", ctrl); end
    endtask

    task automatic test_interlock();
        do_reset();
        feed(8'h81); feed(8'h82);
        interlock = 1'b1; in_ctrl = 8'h83;
        #1;
        n_checks++; if (en !== 3'b110 || fetch !== 1'b0) begin n_fail++; $display("FAIL il_enables: got %b/%b expected 110/0", en, fetch); end
        tick();
        n_checks++; if (valid !== 3'b101 || ctrl !== 24'h810082) begin n_fail++; $display("FAIL il_bubble: got %b/%h expected 101/810082", valid, ctrl); end
        interlock = 1'b0;
        tick();
        n_checks++; if (valid !== 3'b011 || ctrl !== 24'h008283) begin n_fail++; $display("FAIL il_release: got %b/%h expected 011/008283", valid, ctrl); end
        interlock = 1'b1; redirect = 1'b1; in_ctrl = 8'h84;
        tick();
        interlock = 1'b0; redirect = 1'b0;
        n_checks++; if (valid !== 3'b100 || ctrl !== 24'h820000 || squash !== 1'b1) begin n_fail++; $display("FAIL il_redir: got %b/%h/%b expected 100/820000/1", valid, ctrl, squash); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        feed(8'h91); feed(8'h92); feed(8'h93);
        wb_load = 1'b1;
        tick();
        reset = 1'b1; wb_load = 1'b0;
        tick();
        n_checks++; if (valid !== 3'b000 || stall !== 1'b0 || squash !== 1'b1) begin n_fail++; $display("FAIL rst_pause: got %b/%b/%b expected 000/0/1", valid, stall, squash); end
        reset = 1'b0; in_valid = 1'b0;
        tick(); tick(); tick();
        feed(8'hA1); feed(8'hA2);
        redirect = 1'b1;
        tick();
        redirect = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (valid !== 3'b000 || stall !== 1'b0 || squash !== 1'b1) begin n_fail++; $display("FAIL rst_squash: got %b/%b/%b expected 000/0/1", valid, stall, squash); end
        n_checks++; if (a_valid !== 3'b000 || a_squash !== 1'b1) begin n_fail++; $display("FAIL rst_squash_a: got %b/%b expected 000/1", a_valid, a_squash); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_redirect();
        test_load_pause();
        test_ext_stall();
        test_interlock();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
